// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data memory responder: I/O page register map,
// STATUS bit layout, I/O select bit and reset values.
package data_mem_responder_pkg;
  localparam int IO_SEL_BIT = 29;

  localparam logic [3:0] REG_CYCLE  = 4'd0;
  localparam logic [3:0] REG_CMP    = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd2;
  localparam logic [3:0] REG_TXDATA = 4'd3;

  localparam int ST_IRQ     = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  // Which source drives DATA_RD after the last edge; NONE keeps it at zero after reset.
  typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_IO} rd_src_e;
endpackage

// File: rtl/data_mem_responder_be_ram.sv
// Synchronous single-port RAM with per-byte write enables; read-first, no reset.
module be_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    rd <= mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: RAM plus an I/O page with cycle counter,
// compare timer / IRQ flag and a byte TX FIFO drained by valid/ready.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DATA_WE,
  input  logic [3:0]  DATA_BE,
  input  logic [29:0] DATA_ADDR,
  input  logic [31:0] DATA_WD,
  output logic [31:0] DATA_RD,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        IRQ
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic          io_sel, io_wr;
  logic [3:0]    io_idx;
  logic [31:0]   ram_rd, io_rd_q, io_rd_next, status;
  logic [31:0]   cycle, cmp;
  logic          irq_flag, ovf;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_req, push, clr_irq, clr_ovf;
  rd_src_e       rd_src;
  logic          unused_addr;

  assign io_sel      = DATA_ADDR[IO_SEL_BIT];
  assign io_idx      = DATA_ADDR[3:0];
  assign io_wr       = DATA_WE && io_sel;
  assign unused_addr = ^DATA_ADDR[28:RAM_AW];

  be_ram #(.AW(RAM_AW)) u_ram (
    .clk  (CLK),
    .we   (DATA_WE && !io_sel),
    .be   (DATA_BE),
    .addr (DATA_ADDR[RAM_AW-1:0]),
    .wd   (DATA_WD),
    .rd   (ram_rd)
  );

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = !empty && TX_READY;
  assign push_req = io_wr && io_idx == REG_TXDATA && DATA_BE[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign clr_irq  = io_wr && io_idx == REG_STATUS && DATA_BE[0] && DATA_WD[ST_IRQ];
  assign clr_ovf  = io_wr && io_idx == REG_STATUS && DATA_BE[0] && DATA_WD[ST_OVF];

  always_comb begin
    status                    = '0;
    status[ST_IRQ]            = irq_flag;
    status[ST_FULL]           = full;
    status[ST_EMPTY]          = empty;
    status[ST_OVF]            = ovf;
    status[ST_CNT_LSB +: 3]   = 3'(count);
    case (io_idx)
      REG_CYCLE:  io_rd_next = cycle;
      REG_CMP:    io_rd_next = cmp;
      REG_STATUS: io_rd_next = status;
      default:    io_rd_next = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle    <= '0;
      cmp      <= CMP_RESET;
      irq_flag <= 1'b0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_src   <= RD_NONE;
      io_rd_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      cycle    <= cycle + 32'd1;
      irq_flag <= (cycle == cmp) || (irq_flag && !clr_irq);
      ovf      <= (push_req && full && !pop) || (ovf && !clr_ovf);
      rd_src   <= io_sel ? RD_IO : RD_RAM;
      io_rd_q  <= io_rd_next;
      for (int i = 0; i < 4; i++) begin
        if (io_wr && io_idx == REG_CMP && DATA_BE[i]) cmp[8*i +: 8] <= DATA_WD[8*i +: 8];
      end
      if (push) begin
        fifo_mem[wr_ptr] <= DATA_WD[7:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    case (rd_src)
      RD_RAM:  DATA_RD = ram_rd;
      RD_IO:   DATA_RD = io_rd_q;
      default: DATA_RD = '0;
    endcase
  end

  assign TX_DATA  = fifo_mem[rd_ptr];
  assign TX_VALID = !empty;
  assign IRQ      = irq_flag;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder with hand-computed expectations.
module tb_data_mem_responder;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        DATA_WE = 1'b0;
  logic [3:0]  DATA_BE = '0;
  logic [29:0] DATA_ADDR = '0;
  logic [31:0] DATA_WD = '0;
  logic [31:0] DATA_RD;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  localparam logic [29:0] IO       = 30'h2000_0000;
  localparam logic [29:0] A_CYCLE  = IO | 30'd0;
  localparam logic [29:0] A_CMP    = IO | 30'd1;
  localparam logic [29:0] A_STATUS = IO | 30'd2;
  localparam logic [29:0] A_TX     = IO | 30'd3;

  data_mem_responder dut (
    .CLK(CLK), .RESET(RESET), .DATA_WE(DATA_WE), .DATA_BE(DATA_BE),
    .DATA_ADDR(DATA_ADDR), .DATA_WD(DATA_WD), .DATA_RD(DATA_RD),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
    ecount++;
  endtask

  task automatic do_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] wd);
    DATA_WE = 1'b1; DATA_ADDR = a; DATA_BE = be; DATA_WD = wd;
    cyc();
    DATA_WE = 1'b0; DATA_BE = '0;
  endtask

  task automatic do_read(input logic [29:0] a);
    DATA_WE = 1'b0; DATA_ADDR = a;
    cyc();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    ecount = 0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    checks++;
    if (DATA_RD !== 32'h0 || TX_DATA !== 8'h0 || TX_VALID !== 1'b0 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%h tx=%h v=%b irq=%b exp all 0", DATA_RD, TX_DATA, TX_VALID, IRQ);
    end
    RESET = 1'b0;
    ecount = 0;
    do_read(A_STATUS);
    checks++;
    if (DATA_RD !== 32'h0000_0004) begin
      errors++; $display("FAIL reset_status got %h exp %h", DATA_RD, 32'h4);
    end
    do_read(A_CMP);
    checks++;
    if (DATA_RD !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_cmp got %h exp %h", DATA_RD, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_ram_lanes();
    do_write(30'd5, 4'b1111, 32'h1122_3344);
    do_write(30'd5, 4'b0101, 32'hAABB_CCDD);
    do_read(30'd5);
    checks++;
    if (DATA_RD !== 32'h11BB_33DD) begin
      errors++; $display("FAIL ram_lanes got %h exp %h", DATA_RD, 32'h11BB_33DD);
    end
    do_write(30'd5, 4'b0000, 32'hFFFF_FFFF);
    do_read(30'd5);
    checks++;
    if (DATA_RD !== 32'h11BB_33DD) begin
      errors++; $display("FAIL ram_be_zero got %h exp %h", DATA_RD, 32'h11BB_33DD);
    end
    do_read(30'h0000_0405);
    checks++;
    if (DATA_RD !== 32'h11BB_33DD) begin
      errors++; $display("FAIL ram_alias got %h exp %h", DATA_RD, 32'h11BB_33DD);
    end
  endtask

  task automatic test_read_during_write();
    do_write(30'd7, 4'b1111, 32'h0);
    do_write(30'd7, 4'b1111, 32'hDEAD_BEEF);
    checks++;
    if (DATA_RD !== 32'h0) begin
      errors++; $display("FAIL rdw_old got %h exp %h", DATA_RD, 32'h0);
    end
    do_read(30'd7);
    checks++;
    if (DATA_RD !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rdw_new got %h exp %h", DATA_RD, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_timer();
    logic [31:0] v1;
    int n;
    do_reset();
    do_write(A_CMP, 4'b1111, 32'd20);
    while (ecount < 20) cyc();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL irq_early got %b exp 0", IRQ);
    end
    cyc();
    checks++;
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL irq_set got %b exp 1", IRQ);
    end
    do_write(A_STATUS, 4'b0001, 32'h1);
    checks++;
    if (IRQ !== 1'b0) begin
      errors++; $display("FAIL irq_w1c got %b exp 0", IRQ);
    end
    n = ecount;
    do_write(A_CMP, 4'b1111, 32'(n + 2));
    cyc();
    do_write(A_STATUS, 4'b0001, 32'h1);
    checks++;
    if (IRQ !== 1'b1) begin
      errors++; $display("FAIL irq_set_wins got %b exp 1", IRQ);
    end
    do_read(A_CYCLE);
    v1 = DATA_RD;
    checks++;
    if (v1 !== 32'(ecount - 1)) begin
      errors++; $display("FAIL cycle_value got %0d exp %0d", v1, ecount - 1);
    end
    cyc();
    cyc();
    do_read(A_CYCLE);
    checks++;
    if (DATA_RD - v1 !== 32'd3) begin
      errors++; $display("FAIL cycle_delta got %0d exp 3", DATA_RD - v1);
    end
  endtask

  task automatic test_fifo_fill_drain();
    do_reset();
    TX_READY = 1'b0;
    for (int i = 0; i < 5; i++) do_write(A_TX, 4'b0001, 32'h41 + 32'(i));
    do_read(A_STATUS);
    checks++;
    if (DATA_RD !== 32'h0000_004A) begin
      errors++; $display("FAIL fifo_full_status got %h exp %h", DATA_RD, 32'h4A);
    end
    checks++;
    if (TX_VALID !== 1'b1 || TX_DATA !== 8'h41) begin
      errors++; $display("FAIL fifo_head_hold got v=%b d=%h exp v=1 d=41", TX_VALID, TX_DATA);
    end
    TX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (TX_VALID !== 1'b1 || TX_DATA !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", i, TX_VALID, TX_DATA, 8'(8'h41 + i));
      end
      cyc();
    end
    TX_READY = 1'b0;
    checks++;
    if (TX_VALID !== 1'b0) begin
      errors++; $display("FAIL drain_empty got v=%b exp 0", TX_VALID);
    end
    do_read(A_STATUS);
    checks++;
    if (DATA_RD !== 32'h0000_000C) begin
      errors++; $display("FAIL empty_status got %h exp %h", DATA_RD, 32'hC);
    end
    do_write(A_STATUS, 4'b0001, 32'h8);
    do_read(A_STATUS);
    checks++;
    if (DATA_RD !== 32'h0000_0004) begin
      errors++; $display("FAIL ovf_w1c got %h exp %h", DATA_RD, 32'h4);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h62; exp_seq[1] = 8'h63; exp_seq[2] = 8'h64; exp_seq[3] = 8'h55;
    TX_READY = 1'b0;
    for (int i = 0; i < 4; i++) do_write(A_TX, 4'b0001, 32'h61 + 32'(i));
    TX_READY = 1'b1;
    do_write(A_TX, 4'b0001, 32'h55);
    TX_READY = 1'b0;
    do_read(A_STATUS);
    checks++;
    if (DATA_RD !== 32'h0000_0042) begin
      errors++; $display("FAIL full_pushpop_status got %h exp %h", DATA_RD, 32'h42);
    end
    TX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (TX_VALID !== 1'b1 || TX_DATA !== exp_seq[i]) begin
        errors++; $display("FAIL pushpop_drain_%0d got v=%b d=%h exp v=1 d=%h", i, TX_VALID, TX_DATA, exp_seq[i]);
      end
      cyc();
    end
    TX_READY = 1'b0;
    checks++;
    if (TX_VALID !== 1'b0) begin
      errors++; $display("FAIL pushpop_empty got v=%b exp 0", TX_VALID);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    TX_READY = 1'b0;
    do_write(A_CMP, 4'b1111, 32'd3);
    do_write(A_TX, 4'b0001, 32'h71);
    do_write(A_TX, 4'b0001, 32'h72);
    do_write(A_TX, 4'b0001, 32'h73);
    do_read(A_CMP);
    TX_READY = 1'b1;
    cyc();
    checks++;
    if (IRQ !== 1'b1 || TX_VALID !== 1'b1 || TX_DATA !== 8'h72 || DATA_RD !== 32'd3) begin
      errors++;
      $display("FAIL pre_reset got irq=%b v=%b d=%h rd=%h exp irq=1 v=1 d=72 rd=3", IRQ, TX_VALID, TX_DATA, DATA_RD);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (IRQ !== 1'b0 || TX_VALID !== 1'b0 || DATA_RD !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got irq=%b v=%b rd=%h exp 0 0 0", IRQ, TX_VALID, DATA_RD);
    end
    RESET = 1'b0;
    TX_READY = 1'b0;
    ecount = 0;
    do_read(A_CYCLE);
    checks++;
    if (DATA_RD !== 32'h0) begin
      errors++; $display("FAIL cycle_restart got %h exp %h", DATA_RD, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_ram_lanes();
    test_read_during_write();
    test_timer();
    test_fifo_fill_drain();
    test_full_push_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the CPU external data memory interface: accepts word-addressed, byte-enabled reads and writes from the core and serves them from on-chip RAM or a small I/O register page. The I/O page holds a free-running cycle counter, a compare timer with interrupt flag, and a 4-entry byte FIFO. The FIFO is drained toward a downstream serial transmitter by a valid/ready handshake. Sits beside the core at the top level, wired directly to its DATA_* ports.

## Interface

Parameters:
- RAM_AW, 10, RAM word-address width; RAM depth is 2^RAM_AW words.
- FIFO_DEPTH, 4, TX FIFO entries; fixed at a power of two.

Ports:
- CLK  in  1  single clock, shared with the core.
- RESET  in  1  asynchronous, active-high reset.
- DATA_WE  in  1  write strobe for the current address.
- DATA_BE  in  4  byte enables; bit n covers DATA_WD[8n+7:8n].
- DATA_ADDR  in  30  word address.
- DATA_WD  in  32  write data.
- DATA_RD  out  32  registered read data.
- TX_DATA  out  8  FIFO head byte.
- TX_VALID  out  1  FIFO non-empty.
- TX_READY  in  1  downstream accepts TX_DATA this cycle.
- IRQ  out  1  timer interrupt flag.

## Operation

- Address decode:
  - DATA_ADDR[29]=0 selects RAM, indexed by DATA_ADDR[RAM_AW-1:0]; higher bits are ignored, so RAM aliases.
  - DATA_ADDR[29]=1 selects the I/O page, register index DATA_ADDR[3:0].
- RAM writes: on a CLK edge with DATA_WE=1, only enabled byte lanes are written. DATA_WE=1 with DATA_BE=0000 writes nothing.
- RAM reads are read-first: a write and a read to the same word in one cycle return the old contents.
- I/O registers:
  - 0 CYCLE (RO): 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF to 0. Writes are ignored.
  - 1 CMP (RW): compare value; writes honour DATA_BE per byte.
  - 2 STATUS:
    - bit0 IRQ flag, W1C.
    - bit1 FIFO full.
    - bit2 FIFO empty.
    - bit3 overflow sticky, W1C.
    - bits[6:4] FIFO count (0..4).
    - All other bits read 0.
  - 3 TXDATA (WO, reads 0): a write with DATA_BE[0]=1 pushes DATA_WD[7:0].
  - 4..15: reads return 0; writes are ignored.
- Timer: the IRQ flag sets on the edge where CYCLE == CMP. A set and a W1C in the same cycle leave the flag set. IRQ is the flag itself.
- FIFO push and pop:
  - Pop occurs when TX_VALID & TX_READY. TX_DATA is the head entry and is stable while TX_VALID=1 and TX_READY=0.
  - Push when full and no pop in the same cycle: the byte is dropped and overflow is set.
  - Push when full with a pop in the same cycle: the push is accepted and count stays 4.
  - Push when empty: no pop that cycle, since TX_VALID was 0.
  - Pointers wrap modulo FIFO_DEPTH; count is tracked separately so full and empty are unambiguous.

## Timing

- Read latency is 1 cycle. The address, and the write if any, is sampled at edge N; DATA_RD is valid after edge N and holds until edge N+1.
- Reading CYCLE returns the counter value before edge N, i.e. the value at the sampling edge.
- Reading STATUS returns pre-edge state. Effects of a same-cycle write appear on the next read.
- A TXDATA push at edge N makes TX_VALID=1 after edge N; the earliest pop is at edge N+1.
- The IRQ output changes registered, one edge after the compare match.
- Reset values:
  - Outputs: DATA_RD=0, TX_DATA=0, TX_VALID=0, IRQ=0.
  - Internal: CYCLE=0, CMP=0xFFFFFFFF, flag=0, overflow=0, FIFO empty with pointers at 0.
  - RAM contents are not reset.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). Pending pushes and pops are lost.

## Structure

- Shared package holds the I/O register indices (CYCLE=0, CMP=1, STATUS=2, TXDATA=3), the STATUS bit positions, the I/O-select address bit (29), and CMP's reset value.
- One sub-module, be_ram: a 2^RAM_AW x 32 synchronous RAM with per-byte write enables and read-first behaviour, no reset.
- Decode, I/O registers, timer and FIFO live in the top module.

## Test plan

- RAM byte lanes: write 0x11223344 with BE=1111 to word 5, then 0xAABBCCDD with BE=0101 to word 5, then read word 5 -> 0x11BB33DD one cycle later.
- Read-during-write: write 0xDEADBEEF to word 7 (previously 0) while reading word 7 -> DATA_RD=0; the next read returns 0xDEADBEEF.
- Timer:
  - After reset, write CMP=20 -> IRQ=1 one edge after CYCLE reaches 20.
  - Write STATUS=0x1 -> IRQ=0.
  - Read CYCLE twice, 3 cycles apart -> difference is 3.
- FIFO fill and drain:
  - With TX_READY=0, push 0x41, 0x42, 0x43, 0x44, 0x45 -> STATUS reads full=1, count=4, overflow=1.
  - Raise TX_READY -> TX_DATA sequence 0x41..0x44, then TX_VALID=0 and empty=1.
- Full with simultaneous push and pop: with the FIFO full and TX_READY=1, push 0x55 -> count stays 4, overflow not set, 0x55 emerges last.
- Asynchronous reset mid-drain: assert RESET between edges -> TX_VALID, IRQ and DATA_RD go to 0 at once; CYCLE restarts at 0.
